// File: rtl/rv32_pkg.sv
// Shared RV32 encodings for the memory stage: opcodes, funct3 widths,
// exception codes, memory-access FSM states and op-decode helpers.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_LD_MIS  = 2'd1;
  localparam logic [1:0] EXC_ST_MIS  = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  function automatic logic is_load(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    return (instr[6:0] == OP_LOAD) &&
           (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  function automatic logic is_store(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    return (instr[6:0] == OP_STORE) && (f3 == F3_B || f3 == F3_H || f3 == F3_W);
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load data formatter: picks the addressed byte/halfword out of the
// returned word and sign- or zero-extends it according to funct3.
module lsu_load_format
  import rv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctl.sv
// Memory-stage control for the RV32 pipeline: issues data-memory requests
// for aligned loads/stores, stalls earlier stages while one is in flight,
// and fills the memory/writeback pipeline register.
//
// state | meaning
// IDLE  | no transaction; an aligned memop in execute is captured here
// REQ   | request presented, waiting for dmem_req_ready
// RSP   | load accepted, waiting for dmem_rsp_valid
// DONE  | transaction finished (or timed out); stall released for one cycle
module mem_access_ctl
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_exe,
  input  logic [31:0] instr_exe,
  input  logic [31:0] pc_exe,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic        dmem_req_we,
  output logic [3:0]  dmem_req_be,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        stall_mem,
  output logic        valid_mem,
  output logic [31:0] instr_mem,
  output logic [31:0] pc_mem,
  output logic [31:0] result_mem,
  output logic [1:0]  exc_mem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t  state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, load_buf, fmt_data, wdata_fmt;
  logic [3:0]  be_q, be_fmt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        we_q, timeout_q;
  logic        capture, rsp_take, to_hit, timeout_now;

  logic [2:0] f3_exe;
  logic       ld_exe, st_exe, mis_exe, go_exe;

  assign f3_exe  = instr_exe[14:12];
  assign ld_exe  = is_load(instr_exe);
  assign st_exe  = is_store(instr_exe);
  assign mis_exe = (ld_exe | st_exe) & is_misaligned(f3_exe, alu_result[1:0]);
  assign go_exe  = valid_exe & (ld_exe | st_exe) & ~mis_exe;

  // Held low during reset so earlier stages are released immediately.
  assign stall_mem = rst_n & go_exe & (state != ST_DONE);

  assign timeout_now    = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign dmem_req_addr  = addr_q;
  assign dmem_req_we    = we_q;
  assign dmem_req_be    = be_q;
  assign dmem_req_wdata = wdata_q;

  lsu_load_format u_fmt (
    .rdata   (dmem_rsp_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .result  (fmt_data)
  );

  // Store lane placement from the execute-stage address.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = store_data;
    case (f3_exe)
      F3_B: begin
        be_fmt    = 4'b0001 << alu_result[1:0];
        wdata_fmt = {4{store_data[7:0]}};
      end
      F3_H: begin
        be_fmt    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_fmt = {2{store_data[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = store_data;
      end
    endcase
  end

  // Next-state and request control; a store handshake beats the timeout,
  // a load handshake on the last allowed cycle does not.
  always_comb begin
    state_nxt      = state;
    dmem_req_valid = 1'b0;
    capture        = 1'b0;
    rsp_take       = 1'b0;
    to_hit         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_exe) begin
          capture   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready && we_q) begin
          state_nxt = ST_DONE;
        end else if (timeout_now) begin
          to_hit    = 1'b1;
          state_nxt = ST_DONE;
        end else if (dmem_req_ready) begin
          state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (dmem_rsp_valid) begin
          rsp_take  = 1'b1;
          state_nxt = ST_DONE;
        end else if (timeout_now) begin
          to_hit    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Transaction capture, timeout counter and load buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
      load_buf  <= '0;
    end else begin
      if (capture) begin
        addr_q    <= {alu_result[31:2], 2'b00};
        lo_q      <= alu_result[1:0];
        we_q      <= st_exe;
        be_q      <= be_fmt;
        wdata_q   <= wdata_fmt;
        f3_q      <= f3_exe;
        cnt       <= '0;
        timeout_q <= 1'b0;
      end else if (state == ST_REQ || state == ST_RSP) begin
        cnt <= cnt + CW'(1);
      end
      if (to_hit)   timeout_q <= 1'b1;
      if (rsp_take) load_buf  <= fmt_data;
    end
  end

  // Memory/writeback pipeline register; bubbles while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem  <= 1'b0;
      instr_mem  <= '0;
      pc_mem     <= '0;
      result_mem <= '0;
      exc_mem    <= EXC_NONE;
    end else if (valid_exe && !stall_mem) begin
      valid_mem <= 1'b1;
      instr_mem <= instr_exe;
      pc_mem    <= pc_exe;
      if (mis_exe) begin
        result_mem <= '0;
        exc_mem    <= ld_exe ? EXC_LD_MIS : EXC_ST_MIS;
      end else if (go_exe && timeout_q) begin
        result_mem <= '0;
        exc_mem    <= EXC_TIMEOUT;
      end else begin
        result_mem <= (go_exe && !we_q) ? load_buf : alu_result;
        exc_mem    <= EXC_NONE;
      end
    end else begin
      valid_mem <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Directed bench for mem_access_ctl: a vector table for single memory ops
// with an always-ready memory, plus hand sequences for timeout,
// same-cycle ready/response and reset during a transaction.
module tb_mem_access_ctl;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_exe;
  logic [31:0] instr_exe, pc_exe, alu_result, store_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        stall_mem, valid_mem;
  logic [31:0] instr_mem, pc_mem, result_mem;
  logic [1:0]  exc_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_exe(valid_exe), .instr_exe(instr_exe),
    .pc_exe(pc_exe), .alu_result(alu_result), .store_data(store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .stall_mem(stall_mem), .valid_mem(valid_mem), .instr_mem(instr_mem),
    .pc_mem(pc_mem), .result_mem(result_mem), .exc_mem(exc_mem)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] res;
    logic [1:0]  exc;
    logic        req;
    logic        chk_wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, op};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [31:0] rdata,
                               input int lat, input logic [31:0] res, input logic [1:0] exc,
                               input logic req, input logic chk_wr,
                               input logic [3:0] be, input logic [31:0] wdata);
    vec_t v;
    v.instr = instr; v.alu = alu; v.rs2 = rs2; v.rdata = rdata; v.lat = lat;
    v.res = res; v.exc = exc; v.req = req; v.chk_wr = chk_wr; v.be = be; v.wdata = wdata;
    return v;
  endfunction

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    edges, req_cycles;
    logic  got, seen_req, stall_seen, rsp_pend, we_cap, req_prev, stall_prev;
    logic [3:0]  be_cap;
    logic [31:0] wd_cap, addr_cap;
    vec_t  v;

    rst_n = 1'b0; valid_exe = 1'b0; instr_exe = '0; pc_exe = '0; alu_result = '0;
    store_data = '0; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;

    //          instr                 alu          rs2          rdata        lat res          exc req wr be       wdata
    vecs.push_back(mkv(32'h0000_0033,     32'h1234, 0,           0,            1, 32'h1234,     0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_STORE,F3_B), 32'h0103, 32'h0000_00AB, 0,          3, 32'h0103,     0, 1, 1, 4'b1000, 32'hABAB_ABAB));
    vecs.push_back(mkv(mk(OP_LOAD,F3_B),  32'h0102, 0, 32'h0080_0000,          4, 32'hFFFF_FF80, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_LOAD,F3_BU), 32'h0102, 0, 32'h0080_0000,          4, 32'h0000_0080, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_LOAD,F3_W),  32'h0202, 0, 0,                      1, 32'h0,        1, 0, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_STORE,F3_H), 32'h0201, 32'h1111_2222, 0,          1, 32'h0,        2, 0, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_STORE,F3_H), 32'h0202, 32'h1234_BEEF, 0,          3, 32'h0202,     0, 1, 1, 4'b1100, 32'hBEEF_BEEF));
    vecs.push_back(mkv(mk(OP_STORE,F3_W), 32'h0300, 32'hDEAD_BEEF, 0,          3, 32'h0300,     0, 1, 1, 4'b1111, 32'hDEAD_BEEF));
    vecs.push_back(mkv(mk(OP_LOAD,F3_H),  32'h0206, 0, 32'h8001_7FFF,          4, 32'hFFFF_8001, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_LOAD,F3_HU), 32'h0204, 0, 32'h8001_F00D,          4, 32'h0000_F00D, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_LOAD,F3_W),  32'h0208, 0, 32'hCAFE_BABE,          4, 32'hCAFE_BABE, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_LOAD,3'b011),  32'h0055, 0, 0,                    1, 32'h0055,     0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_STORE,3'b011), 32'h0057, 32'h99, 0,               1, 32'h0057,     0, 0, 0, 4'b0000, 0));
    vecs.push_back(mkv(mk(OP_STORE,F3_B), 32'h0001, 32'h0000_005A, 0,          3, 32'h0001,     0, 1, 1, 4'b0010, 32'h5A5A_5A5A));
    vecs.push_back(mkv(mk(OP_LOAD,F3_H),  32'h0203, 0, 0,                      1, 32'h0,        1, 0, 0, 4'b0000, 0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid_mem", 32'(valid_mem), 0);
    chk("rst_result", result_mem, 0);
    chk("rst_exc", 32'(exc_mem), 0);
    chk("rst_req_valid", 32'(dmem_req_valid), 0);
    chk("rst_stall", 32'(stall_mem), 0);
    rst_n = 1'b1;

    // Table: always-ready memory, response one cycle after a load handshake
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      instr_exe = v.instr; pc_exe = 32'h1000 + 32'(i * 4); alu_result = v.alu;
      store_data = v.rs2; valid_exe = 1'b1; dmem_rsp_valid = 1'b0;
      edges = 0; got = 0; seen_req = 0; stall_seen = 0; rsp_pend = 0;
      be_cap = '0; wd_cap = '0; addr_cap = '0; we_cap = 0;
      while (edges < 20 && !got) begin
        #1;
        if (stall_mem) stall_seen = 1;
        if (dmem_req_valid) begin
          seen_req = 1; be_cap = dmem_req_be; wd_cap = dmem_req_wdata;
          addr_cap = dmem_req_addr; we_cap = dmem_req_we;
          if (dmem_req_ready && !dmem_req_we) rsp_pend = 1;
        end
        @(posedge clk);
        @(negedge clk);
        edges++;
        dmem_rsp_valid = rsp_pend; dmem_rsp_rdata = v.rdata; rsp_pend = 0;
        if (valid_mem) got = 1;
      end
      valid_exe = 1'b0; dmem_rsp_valid = 1'b0;
      chk($sformatf("lat[%0d]", i), 32'(edges), 32'(v.lat));
      chk($sformatf("result[%0d]", i), result_mem, v.res);
      chk($sformatf("exc[%0d]", i), 32'(exc_mem), 32'(v.exc));
      chk($sformatf("instr[%0d]", i), instr_mem, v.instr);
      chk($sformatf("pc[%0d]", i), pc_mem, 32'h1000 + 32'(i * 4));
      chk($sformatf("req_seen[%0d]", i), 32'(seen_req), 32'(v.req));
      chk($sformatf("stall_seen[%0d]", i), 32'(stall_seen), 32'(v.req));
      if (v.req) chk($sformatf("addr[%0d]", i), addr_cap, {v.alu[31:2], 2'b00});
      if (v.chk_wr) begin
        chk($sformatf("be[%0d]", i), 32'(be_cap), 32'(v.be));
        chk($sformatf("wdata[%0d]", i), wd_cap, v.wdata);
        chk($sformatf("we[%0d]", i), 32'(we_cap), 1);
      end
    end

    // Timeout: load with ready held low, limit 4 cycles
    @(negedge clk);
    dmem_req_ready = 1'b0;
    instr_exe = mk(OP_LOAD, F3_W); pc_exe = 32'h2000; alu_result = 32'h0400; valid_exe = 1'b1;
    edges = 0; got = 0; req_cycles = 0; req_prev = 1; stall_prev = 1;
    while (edges < 40 && !got) begin
      #1;
      req_prev = dmem_req_valid; stall_prev = stall_mem;
      if (dmem_req_valid) req_cycles++;
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (valid_mem) got = 1;
    end
    valid_exe = 1'b0;
    chk("to_req_cycles", 32'(req_cycles), 4);
    chk("to_lat", 32'(edges), 6);
    chk("to_exc", 32'(exc_mem), 3);
    chk("to_result", result_mem, 0);
    chk("to_req_drop", 32'(req_prev), 0);
    chk("to_stall_drop", 32'(stall_prev), 0);

    // Ready and response in the same REQ cycle: response ignored
    @(negedge clk);
    instr_exe = mk(OP_LOAD, F3_W); pc_exe = 32'h2004; alu_result = 32'h0500; valid_exe = 1'b1;
    @(negedge clk);
    #1 chk("same_req_valid", 32'(dmem_req_valid), 1);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1111_1111;
    @(negedge clk);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    #1 chk("same_rsp_stall", 32'(stall_mem), 1);
    @(negedge clk);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h2222_2222;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("same_done_bubble", 32'(valid_mem), 0);
    @(negedge clk);
    valid_exe = 1'b0;
    chk("same_valid", 32'(valid_mem), 1);
    chk("same_result", result_mem, 32'h2222_2222);

    // Reset while in REQ: request withdrawn at once
    @(negedge clk);
    instr_exe = mk(OP_LOAD, F3_W); pc_exe = 32'h2008; alu_result = 32'h0600; valid_exe = 1'b1;
    @(negedge clk);
    #1 chk("rreq_before", 32'(dmem_req_valid), 1);
    #1 rst_n = 1'b0;
    #1 chk("rreq_req_valid", 32'(dmem_req_valid), 0);
    chk("rreq_stall", 32'(stall_mem), 0);
    valid_exe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in RSP; a late response must not reach result_mem
    dmem_req_ready = 1'b1;
    @(negedge clk);
    instr_exe = mk(OP_LOAD, F3_W); pc_exe = 32'h200C; alu_result = 32'h0604; valid_exe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rrsp_stall_before", 32'(stall_mem), 1);
    #1 rst_n = 1'b0;
    #1 chk("rrsp_req_valid", 32'(dmem_req_valid), 0);
    chk("rrsp_stall", 32'(stall_mem), 0);
    chk("rrsp_valid_mem", 32'(valid_mem), 0);
    chk("rrsp_result", result_mem, 0);
    valid_exe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_rsp_result", result_mem, 0);
    chk("late_rsp_valid", 32'(valid_mem), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctl.md
Name: mem_access_ctl

Overview:
- Memory-stage control for the RV32 pipeline; consumes the execute-stage register outputs (instruction, pc, ALU result, rs2 data) and produces the memory/writeback pipeline register.
- Drives a valid/ready data-memory request channel for loads and stores, with a separate response channel for load data.
- Aligns store data and byte enables; extracts and extends load data.
- Raises stall toward earlier stages while a transaction is outstanding; passes non-memory instructions through in one cycle.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+RSP before aborting with a bus-timeout exception; must be ≥1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_exe  in  1  execute register holds a real instruction.
- instr_exe  in  32  instruction in execute.
- pc_exe  in  32  its pc.
- alu_result  in  32  ALU output; effective address for load/store.
- store_data  in  32  rs2 value.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_addr  out  32  word address, {alu_result[31:2],2'b00}.
- dmem_req_we  out  1  1 = store.
- dmem_req_be  out  4  byte enables.
- dmem_req_wdata  out  32  lane-replicated store data.
- dmem_rsp_valid  in  1  load data valid, one-cycle pulse.
- dmem_rsp_rdata  in  32  load word.
- stall_mem  out  1  combinational; hold execute register this cycle.
- valid_mem  out  1  memory register valid.
- instr_mem  out  32  memory register instruction.
- pc_mem  out  32  memory register pc.
- result_mem  out  32  ALU result or formatted load data.
- exc_mem  out  2  0 none, 1 load misalign, 2 store misalign, 3 bus timeout.

Behaviour:
- Reset:
  - Async assert → state IDLE, all registered outputs 0, dmem_req_valid 0 immediately.
  - An outstanding transaction is abandoned; a response arriving after reset is ignored.
- Memory op definition:
  - Load = opcode 0000011 with funct3 in {000,001,010,100,101}.
  - Store = opcode 0100011 with funct3 in {000,001,010}.
  - Other funct3 on these opcodes are treated as non-memory: pass through, exc 0.
- Misalignment:
  - Halfword ops with addr[0]=1 are misaligned.
  - Word ops with addr[1:0]≠0 are misaligned.
  - No request is issued; no stall; exc 1 (load) or 2 (store); result_mem 0.
- FSM states: IDLE, REQ, RSP, DONE.
  - IDLE:
    - Aligned memory op with valid_exe → capture addr/we/be/wdata/funct3, go to REQ.
    - stall_mem = 1.
  - REQ:
    - dmem_req_valid = 1; addr/we/be/wdata held stable until handshake.
    - On ready: store → DONE; load → RSP.
    - stall_mem = 1.
  - RSP:
    - On dmem_rsp_valid, latch formatted data → DONE.
    - rsp_valid outside RSP is ignored.
    - stall_mem = 1.
  - DONE:
    - stall_mem = 0; unconditionally → IDLE.
- stall_mem = valid_exe & aligned memop & state≠DONE.
- Pipeline register update on every edge:
  - If valid_exe & !stall_mem: valid_mem ← 1 and instr/pc captured.
    - Result is the load buffer for loads, alu_result otherwise.
    - exc is set per the misalignment rules or latched timeout.
  - Else: valid_mem ← 0 (bubble). instr/pc/result hold their values.
- Latency (valid_mem edges after the instruction reaches execute):
  - Non-memory or misaligned: 1.
  - Store with ready in its first REQ cycle: 3.
  - Load with ready and rsp each one cycle: 4.
- Timeout:
  - Counter clears on entering REQ and increments in REQ/RSP.
  - Reaching TIMEOUT_CYCLES → DONE with exc 3, result 0; dmem_req_valid drops.
- Store formatting:
  - SB: be = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Load formatting:
  - LB/LBU select byte addr[1:0] of rdata.
  - LH/LHU select halfword addr[1] of rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses rdata unchanged.
- Ready and rsp_valid in the same cycle while in REQ: the response is ignored; the FSM still moves to RSP.

Decomposition:
- Shared package rv32_pkg:
  - Opcode constants OP_LOAD, OP_STORE.
  - funct3 constants F3_B/H/W/BU/HU.
  - exc code constants.
  - FSM state encoding.
- One combinational sub-module, lsu_load_format: (rdata, addr[1:0], funct3) → 32-bit result.

Test Plan:
- ADD x, alu_result=0x1234 → valid_mem next edge, result_mem 0x1234, stall_mem never high.
- SB addr 0x103, rs2 0xAB, ready immediate → be 1000, wdata 0xABABABAB, valid_mem 3 edges after entry, exc 0.
- LB addr 0x102, rdata 0x00800000, ready and rsp each one cycle → result 0xFFFFFF80; LBU same inputs → 0x00000080.
- LW addr 0x202 → no dmem_req_valid, exc 1, valid_mem after 1 edge; SH addr 0x201 → exc 2.
- Load with ready held low, TIMEOUT_CYCLES=4 → exc 3 after 4 cycles, result 0, req_valid drops.
- rst_n asserted while in RSP → req_valid/stall/valid_mem 0 immediately; a subsequent rsp_valid does not update result_mem.
